// File: rtl/kd_node_ctrl_if.sv
// kd_node_ctrl_if: command/data/alert links between a kd-tree node, its parent and its two children.
interface kd_node_ctrl_if #(
   parameter int CMD_W = 3,
   parameter int PT_W  = 16
);
   logic             alert_top, alert_left, alert_right;
   logic [CMD_W-1:0] cmd_from_top, cmd_from_left, cmd_from_right;
   logic [PT_W-1:0]  data_from_top, data_from_left, data_from_right;
   logic             alert_to_top, alert_to_left, alert_to_right;
   logic [CMD_W-1:0] cmd_to_top, cmd_to_left, cmd_to_right;
   logic [PT_W-1:0]  data_to_top, data_to_left, data_to_right;
   modport master (
      output alert_top, alert_left, alert_right, cmd_from_top, cmd_from_left, cmd_from_right,
             data_from_top, data_from_left, data_from_right,
      input  alert_to_top, alert_to_left, alert_to_right, cmd_to_top, cmd_to_left, cmd_to_right,
             data_to_top, data_to_left, data_to_right
   );
   modport slave (
      input  alert_top, alert_left, alert_right, cmd_from_top, cmd_from_left, cmd_from_right,
             data_from_top, data_from_left, data_from_right,
      output alert_to_top, alert_to_left, alert_to_right, cmd_to_top, cmd_to_left, cmd_to_right,
             data_to_top, data_to_left, data_to_right
   );
endinterface

// File: rtl/kd_node_ctrl.sv
// kd_node_ctrl: kd-tree node with configure/load/report and one compare-exchange sort step per SORT.
// Define KD_NODE_TIMEOUT_EN to add a watchdog that aborts stuck wait states after TIMEOUT_CYC cycles.
module kd_node_ctrl #(
   parameter int COORD_W     = 8,
   parameter int DIM         = 2,
   parameter int MAX_DEPTH   = 8,
   parameter int CMD_W       = 3,
   parameter int TIMEOUT_CYC = 64,
   localparam int PT_W  = DIM * COORD_W,
   localparam int DEP_W = $clog2(MAX_DEPTH),
   localparam int AX_W  = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              has_left,
   input  logic              has_right,
   kd_node_ctrl_if.slave     bus,
   output logic [PT_W-1:0]   point_out,
   output logic [DEP_W-1:0]  depth_out,
   output logic [AX_W-1:0]   axis_out,
   output logic              busy,
   output logic              proto_err
);
   localparam logic [CMD_W-1:0] C_NOP = 0, C_CFG = 1, C_ACK = 2, C_LOAD = 3, C_SORT = 4, C_REP = 5, C_SWAP = 6;
   localparam logic [1:0] S_IDLE = 2'd0, S_WACK = 2'd1, S_WPTS = 2'd2, S_WSWP = 2'd3;

   logic [1:0]       state, state_n, pend, pend_c, pend_n;
   logic [PT_W-1:0]  lpt, rpt, lpt_n, rpt_n, point_n, t_d, l_d, r_d, ch_data;
   logic [DEP_W-1:0] dep_n, cfg_dep, ch_dep;
   logic [AX_W-1:0]  ax_n, cfg_ax_raw, cfg_ax, ch_ax;
   logic [CMD_W-1:0] l_c, r_c;
   logic             ack_l, ack_r, err_l, err_r, top_err, top_go, done, kids;
   logic             left_bad, right_bad, t_v, l_v, r_v, tmo;
   logic [COORD_W-1:0] pc;

   function automatic logic [COORD_W-1:0] crd(input logic [PT_W-1:0] p, input logic [AX_W-1:0] a);
      return p[int'(a)*COORD_W +: COORD_W];
   endfunction

   assign kids    = has_left || has_right;
   assign ack_l   = bus.alert_left && bus.cmd_from_left == C_ACK && pend[0];
   assign ack_r   = bus.alert_right && bus.cmd_from_right == C_ACK && pend[1];
   assign err_l   = bus.alert_left && !ack_l;
   assign err_r   = bus.alert_right && !ack_r;
   assign top_err = bus.alert_top && ((busy && bus.cmd_from_top != C_NOP) || bus.cmd_from_top > C_SWAP);
   assign top_go  = bus.alert_top && !busy && !top_err;
   assign pend_c  = pend & ~{ack_r, ack_l};
   assign done    = busy && pend_c == 2'b00;
   assign lpt_n   = ack_l ? bus.data_from_left : lpt;
   assign rpt_n   = ack_r ? bus.data_from_right : rpt;
   assign pc        = crd(point_out, axis_out);
   assign left_bad  = has_left && crd(lpt_n, axis_out) > pc;
   assign right_bad = has_right && crd(rpt_n, axis_out) < pc;
   // Out-of-range axes collapse to 0 at configuration time, so axis_out is always valid.
   assign cfg_ax_raw = bus.data_from_top[AX_W-1:0];
   assign cfg_ax     = (int'(cfg_ax_raw) < DIM) ? cfg_ax_raw : '0;
   assign cfg_dep    = bus.data_from_top[AX_W+DEP_W-1:AX_W];
   assign ch_ax      = (int'(cfg_ax) == DIM - 1) ? '0 : cfg_ax + AX_W'(1);
   assign ch_dep     = (int'(cfg_dep) >= MAX_DEPTH - 1) ? DEP_W'(MAX_DEPTH - 1) : cfg_dep + DEP_W'(1);
   assign ch_data    = PT_W'({ch_dep, ch_ax});

`ifdef KD_NODE_TIMEOUT_EN
   logic [$clog2(TIMEOUT_CYC)-1:0] cnt;
   assign tmo = busy && cnt == ($clog2(TIMEOUT_CYC))'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk)
      cnt <= (rst || !busy || state_n != state) ? '0 : cnt + 1'b1;
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_n = state;
      pend_n  = pend_c;
      point_n = point_out;
      dep_n   = depth_out;
      ax_n    = axis_out;
      t_v = 1'b0;
      t_d = '0;
      l_v = 1'b0;
      r_v = 1'b0;
      l_c = C_REP;
      r_c = C_REP;
      l_d = point_out;
      r_d = point_out;
      if (top_go) begin
         case (bus.cmd_from_top)
            C_CFG: begin
               ax_n    = cfg_ax;
               dep_n   = cfg_dep;
               l_v     = has_left;
               r_v     = has_right;
               l_c     = C_CFG;
               r_c     = C_CFG;
               l_d     = ch_data;
               r_d     = ch_data;
               state_n = kids ? S_WACK : S_IDLE;
               pend_n  = {has_right, has_left};
               t_v     = !kids;
            end
            C_LOAD, C_SWAP: begin
               point_n = bus.data_from_top;
               t_v     = 1'b1;
            end
            C_REP: begin
               t_v = 1'b1;
               t_d = point_out;
            end
            C_SORT: begin
               l_v     = has_left;
               r_v     = has_right;
               state_n = kids ? S_WPTS : S_IDLE;
               pend_n  = {has_right, has_left};
               t_v     = !kids;
            end
            default: ;
         endcase
      end else if (done) begin
         state_n = S_IDLE;
         t_v     = 1'b1;
         t_d     = (state == S_WSWP) ? PT_W'(1) : '0;
         // One exchange per SORT; left wins when both children violate.
         if (state == S_WPTS && (left_bad || right_bad)) begin
            t_v     = 1'b0;
            state_n = S_WSWP;
            point_n = left_bad ? lpt_n : rpt_n;
            l_v     = left_bad;
            r_v     = !left_bad;
            l_c     = C_SWAP;
            r_c     = C_SWAP;
            pend_n  = left_bad ? 2'b01 : 2'b10;
         end
      end else if (tmo) begin
         state_n = S_IDLE;
         pend_n  = 2'b00;
         t_v     = 1'b1;
         t_d     = PT_W'(2);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         pend               <= 2'b00;
         lpt                <= '0;
         rpt                <= '0;
         point_out          <= '0;
         depth_out          <= '0;
         axis_out           <= '0;
         busy               <= 1'b0;
         proto_err          <= 1'b0;
         bus.alert_to_top   <= 1'b0;
         bus.alert_to_left  <= 1'b0;
         bus.alert_to_right <= 1'b0;
         bus.cmd_to_top     <= '0;
         bus.cmd_to_left    <= '0;
         bus.cmd_to_right   <= '0;
         bus.data_to_top    <= '0;
         bus.data_to_left   <= '0;
         bus.data_to_right  <= '0;
      end else begin
         state              <= state_n;
         pend               <= pend_n;
         lpt                <= lpt_n;
         rpt                <= rpt_n;
         point_out          <= point_n;
         depth_out          <= dep_n;
         axis_out           <= ax_n;
         busy               <= state_n != S_IDLE;
         proto_err          <= proto_err || top_err || err_l || err_r || tmo;
         bus.alert_to_top   <= t_v;
         bus.alert_to_left  <= l_v;
         bus.alert_to_right <= r_v;
         if (t_v) begin
            bus.cmd_to_top  <= C_ACK;
            bus.data_to_top <= t_d;
         end
         if (l_v) begin
            bus.cmd_to_left  <= l_c;
            bus.data_to_left <= l_d;
         end
         if (r_v) begin
            bus.cmd_to_right  <= r_c;
            bus.data_to_right <= r_d;
         end
      end
   end
endmodule

// File: doc/kd_node_ctrl.md
Name: kd_node_ctrl

Overview:
- Parametrised kd-tree node controller, successor to the fixed-width sort node.
- Holds one DIM-dimensional point plus its depth and split axis.
- Talks to its parent (top) and to up to two children (left, right) over a command/data/alert channel per direction.
- Supports configure, load and one compare-exchange sort step per command, with child-ack aggregation. A top-level sequencer issues sort steps repeatedly until no node reports a swap.

Parameters:
- COORD_W, 8, bits per coordinate (unsigned).
- DIM, 2, dimensions per point. PT_W = DIM*COORD_W.
- MAX_DEPTH, 8, tree depth bound. DEP_W = clog2(MAX_DEPTH). AX_W = max(1, clog2(DIM)).
- CMD_W, 3, command field width.
- TIMEOUT_CYC, 64, watchdog limit; used only with the optional feature.

Ports:
- clk in 1: clock.
- rst in 1: reset.
- has_left, has_right in 1 each: child present (static).
- alert_top, alert_left, alert_right in 1 each: one-cycle valid for the incoming cmd/data of that side.
- cmd_from_top, cmd_from_left, cmd_from_right in CMD_W each: incoming commands.
- data_from_top, data_from_left, data_from_right in PT_W each: incoming data.
- alert_to_top, alert_to_left, alert_to_right out 1 each: one-cycle valid for the outgoing cmd/data of that side.
- cmd_to_top, cmd_to_left, cmd_to_right out CMD_W each: outgoing commands.
- data_to_top, data_to_left, data_to_right out PT_W each: outgoing data.
- point_out out PT_W: stored point.
- depth_out out DEP_W: stored depth.
- axis_out out AX_W: stored split axis.
- busy out 1: state != IDLE.
- proto_err out 1: sticky protocol-error flag.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All outputs 0, including point, depth, axis and proto_err.
  - Pending ack flags cleared.
  - Reset mid-operation aborts with no ack sent up.
- Command codes: NOP=0, CONFIG=1, ACK=2, LOAD=3, SORT=4, REPORT=5, SWAP=6.
- Output rules:
  - All outputs are registered.
  - An alert_to_* pulse is exactly 1 cycle; cmd/data hold their last value otherwise.
  - Input sampled in cycle N → response at N+1 at the earliest.
- CONFIG data layout: axis = data[AX_W-1:0], depth = data[AX_W+DEP_W-1:AX_W].
- IDLE, CONFIG from top:
  - Latch depth and axis.
  - Send CONFIG to each present child with depth+1 (saturating at MAX_DEPTH-1) and child axis = (axis==DIM-1) ? 0 : axis+1.
  - Go to WAIT_ACK. With no children, send ACK to top at N+1 instead.
- IDLE, LOAD from top: point <= data_from_top; ACK to top at N+1.
- IDLE, REPORT from top: ACK to top at N+1 with data = point.
- IDLE, SWAP from top: point <= data_from_top; ACK to top at N+1.
- IDLE, SORT from top:
  - No children: ACK to top at N+1 with data = 0.
  - Otherwise: REPORT to each present child, then go to WAIT_PTS.
- WAIT_ACK / WAIT_PTS / WAIT_SWAP:
  - Keep per-child pending flags.
  - An ACK with alert from a child clears its flag. Left and right in the same cycle both clear.
  - WAIT_PTS also latches the reported child point.
  - Exit the cycle after the last flag clears.
- WAIT_ACK exit: ACK to top.
- WAIT_PTS exit, compare on the current axis coordinate only:
  - left_bad = L[axis] > P[axis]; right_bad = R[axis] < P[axis]. Equal is not a violation.
  - If left_bad: point <= L, send SWAP carrying old P to left, go to WAIT_SWAP.
  - Else if right_bad: same exchange with right.
  - Else: ACK to top with data = 0.
  - Only one exchange per SORT; left has priority.
- WAIT_SWAP exit: ACK to top with data[0]=1.
- Protocol errors (all set proto_err, sticky until rst; the offending input is otherwise ignored):
  - Top command while busy.
  - Child ACK while not waiting on that child.
  - Child command other than ACK.
  - Unknown code.
- Axis index: an axis >= DIM is treated as 0.

Optional Feature:
- Macro KD_NODE_TIMEOUT_EN.
- Enabled:
  - Cycle counter runs in every wait state and clears on state entry.
  - At TIMEOUT_CYC cycles: set proto_err, clear pending flags, send ACK to top with data[1]=1, return to IDLE.
- Disabled: no counter; wait states hold indefinitely.

Test Plan (DIM=2, COORD_W=8):
1. Reset, then LOAD data=0x0305 → ACK to top at N+1, point_out=0x0305, busy low after. All outputs were 0 during rst.
2. has_left=has_right=1, CONFIG axis=1 depth=2 → both children receive axis=0 depth=3. Right ACK at +3, left ACK at +5 → ACK to top exactly 1 cycle after the left ACK.
3. Point x=5 y=5, axis=0, SORT, left reports x=9 y=1, right reports x=7 y=0 → SWAP carrying 0x0505 to left, point_out=0x0109, after left ACK → ACK up with data[0]=1.
4. Same as 3 but left x=5 (equal) → no violation, ACK up data=0. Point unchanged.
5. Leaf (no children) SORT → ACK at N+1 data=0. Then CONFIG issued while a WAIT state is active in another setup → proto_err=1 and stays 1 until rst.
6. With KD_NODE_TIMEOUT_EN, TIMEOUT_CYC=64, SORT with the right child silent → ACK up with data[1]=1 at cycle 64 after entering WAIT_PTS, proto_err=1. Without the macro → busy stays high.
